// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the uart_tx arbiter: the arbiter state encoding,
// the default byte width and the default busy-timeout budget.
// No ports; imported by uart_tx_arbiter.
package uart_arb_pkg;

  localparam int NUM_DATA_BITS        = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCEPT    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selector. Starting at index rr_ptr and searching
// upward with wrap-around, returns the first requester whose valid is set.
//   req_valid  in   NUM_REQ  per-requester valid
//   rr_ptr     in   PTR_W    highest-priority index for this search
//   pick       out  NUM_REQ  one-hot winner (0 when nothing is valid)
//   any_valid  out  1        at least one requester is valid
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_pick;

  always_comb begin
    // Rotate so rr_ptr lands on bit 0; the lowest set bit is then the winner.
    rot      = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    rot_pick = rot & (~rot + NUM_REQ'(1));
    // Rotate the winner back: shift the doubled vector left and keep the top half.
    pick      = NUM_REQ'(({rot_pick, rot_pick} << rr_ptr) >> NUM_REQ);
    any_valid = |req_valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
// Ownership is granted round-robin per packet; the owner keeps the
// transmitter until its last byte completes. Each byte is driven through
// the uart_tx write/busy/done handshake with a busy-timeout guard.
//   clk50      in   1                  system clock
//   reset      in   1                  asynchronous active-high reset
//   req_valid  in   NUM_REQ            per-requester byte valid
//   req_data   in   NUM_REQ*DATA_BITS  requester i at [i*DATA_BITS +: DATA_BITS]
//   req_last   in   NUM_REQ            byte is the last of its packet
//   req_ready  out  NUM_REQ            byte accepted when valid && ready
//   grant      out  NUM_REQ            one-hot current owner, 0 when idle
//   pause      in   1                  blocks new grants, never splits a packet
//   tx_write   out  1                  uart_tx write strobe
//   tx_byte    out  DATA_BITS          uart_tx data
//   tx_busy    in   1                  uart_tx busy
//   tx_done    in   1                  uart_tx done
//   tx_error   in   1                  uart_tx error
//   arb_error  out  1                  sticky: busy timeout or tx_error seen
//   pkt_done   out  1                  one-cycle pulse after a packet's last byte
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_BITS    = NUM_DATA_BITS,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                           clk50,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  input  logic                           pause,
  output logic                           tx_write,
  output logic [DATA_BITS-1:0]           tx_byte,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  input  logic                           tx_error,
  output logic                           arb_error,
  output logic                           pkt_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_prev_q, busy_prev_d;
  logic                 arb_error_q, arb_error_d;
  logic                 pkt_done_q, pkt_done_d;

  logic [NUM_REQ-1:0]   pick;
  logic                 any_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
  logic                 complete;

  // Unpack the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  // Keep the owner's index alongside its one-hot grant so the data mux and
  // the pointer advance need no encoder on the registered path.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  // A transfer finishes on busy falling or an explicit done strobe.
  assign complete = (busy_prev_q && !tx_busy) || tx_done;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    tx_byte_d   = tx_byte_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    busy_prev_d = tx_busy;
    arb_error_d = arb_error_q;
    pkt_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!pause && any_valid) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ACCEPT;
        end
      end

      ACCEPT: begin
        if (req_valid[gidx_q]) begin
          tx_byte_d = req_bytes[gidx_q];
          last_d    = req_last[gidx_q];
          cnt_d     = '0;
          state_d   = START;
        end
      end

      START: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never took the byte: drop the rest of this packet and
          // move priority past the stalled owner.
          arb_error_d = 1'b1;
          grant_d     = '0;
          rr_ptr_d    = next_ptr;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (complete) begin
          if (tx_error) arb_error_d = 1'b1;
          if (last_q) begin
            pkt_done_d = 1'b1;
            grant_d    = '0;
            rr_ptr_d   = next_ptr;
            state_d    = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      tx_byte_q   <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      busy_prev_q <= 1'b0;
      arb_error_q <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      tx_byte_q   <= tx_byte_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      busy_prev_q <= busy_prev_d;
      arb_error_q <= arb_error_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign req_ready = (state_q == ACCEPT) ? grant_q : '0;
  // Drop the strobe as soon as uart_tx reports busy so it sees one write per byte.
  assign tx_write  = (state_q == START) && !tx_busy;
  assign tx_byte   = tx_byte_q;
  assign grant     = grant_q;
  assign arb_error = arb_error_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with two requesters and a
// behavioural uart_tx (busy for 10 cycles per byte, or never in timeout mode).
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  wire  [1:0]  req_valid;
  wire  [15:0] req_data;
  wire  [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        pause = 1'b0;
  logic        tx_write;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_error;
  logic        arb_error;
  logic        pkt_done;

  always #5 clk50 = ~clk50;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .DATA_BITS    (8),
    .BUSY_TIMEOUT (64)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .pause     (pause),
    .tx_write  (tx_write),
    .tx_byte   (tx_byte),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .arb_error (arb_error),
    .pkt_done  (pkt_done)
  );

  // ---------------- uart_tx model ----------------
  int   busy_cnt;
  logic model_dead = 1'b0;
  always @(posedge clk50 or posedge reset) begin
    if (reset)                          busy_cnt <= 0;
    else if (busy_cnt > 0)              busy_cnt <= busy_cnt - 1;
    else if (tx_write && !model_dead)   busy_cnt <= 10;
  end
  assign tx_busy  = (busy_cnt != 0);
  assign tx_done  = 1'b0;
  assign tx_error = 1'b0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  // ---------------- requester drivers ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [8:0] q[$];
    logic       v = 1'b0;
    logic [7:0] d = 8'h00;
    logic       l = 1'b0;
    logic       hs;
    assign req_valid[gi]        = v;
    assign req_data[gi*8 +: 8]  = d;
    assign req_last[gi]         = l;
    initial begin
      forever begin
        @(negedge clk50);
        hs = v && req_ready[gi];
        @(posedge clk50);
        #1;
        if (hs && q.size() > 0) void'(q.pop_front());
        if (q.size() > 0) begin
          v = 1'b1;
          {l, d} = q[0];
        end else begin
          v = 1'b0;
        end
      end
    end
  end

  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    if (r == 0) g_src[0].q.push_back({last, b});
    else        g_src[1].q.push_back({last, b});
    exp_q.push_back(b);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  logic wr_prev  = 1'b0;
  int   wr_count = 0;
  logic saw_r1   = 1'b0;
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk50);
      if (tx_write && !wr_prev) begin
        wr_count++;
        $display("[%0t] tx_write byte=%02h grant=%b", $time, tx_byte, grant);
        check("sb_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte", tx_byte, e);
        end
      end
      wr_prev = tx_write;
      if (req_ready[1] || grant[1]) saw_r1 = 1'b1;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_grant(input string nm, input logic [1:0] exp);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk50);
      if (grant != 2'b00) break;
    end
    check(nm, grant, exp);
  endtask

  task automatic wait_done(input string nm, input logic [1:0] g);
    logic ok   = 1'b0;
    logic held = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk50);
      if (pkt_done) begin
        ok = 1'b1;
        break;
      end
      if (grant !== g) held = 1'b0;
    end
    check({nm, "_pkt_done"}, ok, 1);
    check({nm, "_grant_held"}, held, 1);
    check({nm, "_grant_released"}, grant, 0);
  endtask

  task automatic wait_write(input string nm);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk50);
      if (tx_write) break;
    end
    check(nm, tx_write, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          req;
    int          nbytes;
    logic [23:0] bytes;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int n;
    logic bad;

    tbl[0] = '{0, 3, 24'hA55AFF, 2'b01};
    tbl[1] = '{1, 1, 24'h3C0000, 2'b10};
    tbl[2] = '{0, 2, 24'h010200, 2'b01};
    tbl[3] = '{1, 3, 24'hC0FFEE, 2'b10};

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk50);
    check("rst_grant", grant, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_write", tx_write, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_arb_error", arb_error, 0);
    check("rst_pkt_done", pkt_done, 0);
    reset = 1'b0;
    @(negedge clk50);

    // Single-requester packets from the table
    for (int i = 0; i < 4; i++) begin
      wc0 = wr_count;
      for (int k = 0; k < tbl[i].nbytes; k++)
        push_byte(tbl[i].req, tbl[i].bytes[23-8*k -: 8], k == tbl[i].nbytes - 1);
      wait_grant("tbl_grant", tbl[i].exp_grant);
      wait_done("tbl", tbl[i].exp_grant);
      check("tbl_write_pulses", wr_count - wc0, tbl[i].nbytes);
    end

    // Contention twice: req 0 wins both times because req 1 was served last
    for (int rep = 0; rep < 2; rep++) begin
      push_byte(0, 8'h11, 1'b0);
      push_byte(0, 8'h22, 1'b1);
      push_byte(1, 8'h33, 1'b0);
      push_byte(1, 8'h44, 1'b1);
      wait_grant("cont_first", 2'b01);
      wait_done("cont_r0", 2'b01);
      wait_grant("cont_second", 2'b10);
      wait_done("cont_r1", 2'b10);
    end

    // No interleave: req 1 arrives mid-packet
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b0);
    push_byte(0, 8'hA3, 1'b1);
    wait_write("ni_first_write");
    saw_r1 = 1'b0;
    push_byte(1, 8'hB7, 1'b1);
    wait_done("ni_r0", 2'b01);
    check("ni_r1_blocked", saw_r1, 0);
    wait_grant("ni_r1_grant", 2'b10);
    wait_done("ni_r1", 2'b10);

    // Pause mid-packet, then a blocked request
    push_byte(0, 8'hB1, 1'b0);
    push_byte(0, 8'hB2, 1'b1);
    wait_write("pause_first_write");
    pause = 1'b1;
    wait_done("pause_pkt", 2'b01);
    push_byte(1, 8'hC3, 1'b1);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk50);
      if (grant != 2'b00) bad = 1'b1;
    end
    check("pause_no_grant", bad, 0);
    pause = 1'b0;
    wait_grant("pause_release", 2'b10);
    wait_done("pause_r1", 2'b10);

    // Busy timeout
    model_dead = 1'b1;
    push_byte(0, 8'hD4, 1'b1);
    wait_write("to_write");
    n = 0;
    while (tx_write && n < 200) begin
      n++;
      @(negedge clk50);
    end
    check("to_write_cycles", n, 64);
    check("to_arb_error", arb_error, 1);
    check("to_grant", grant, 0);
    model_dead = 1'b0;
    push_byte(1, 8'hE6, 1'b1);
    wait_grant("to_next_grant", 2'b10);
    wait_done("to_next", 2'b10);
    check("arb_error_sticky", arb_error, 1);

    // Asynchronous reset while waiting for uart_tx to finish
    push_byte(0, 8'h5C, 1'b0);
    push_byte(0, 8'h6D, 1'b1);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk50);
      if (tx_busy) break;
    end
    check("mid_rst_busy", tx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_tx_write", tx_write, 0);
    check("mid_rst_tx_byte", tx_byte, 0);
    check("mid_rst_arb_error", arb_error, 0);
    check("mid_rst_pkt_done", pkt_done, 0);
    g_src[0].q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    push_byte(0, 8'h12, 1'b0);
    push_byte(0, 8'h34, 1'b1);
    wait_grant("post_rst_grant", 2'b01);
    wait_done("post_rst", 2'b01);
    check("post_rst_arb_error", arb_error, 0);

    repeat (3) @(negedge clk50);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
